// File: rtl/l2_pkg.sv
// Shared types and ASCII constants for the Lab2 command collector.
package l2_pkg;

  typedef enum logic [2:0] {
    S_A,
    S_OP,
    S_B,
    S_TERM,
    S_START,
    S_WAIT
  } l2_state_e;

  localparam logic [7:0] ASC_PLUS  = 8'h2B;
  localparam logic [7:0] ASC_MINUS = 8'h2D;
  localparam logic [7:0] ASC_CR    = 8'h0D;
  localparam logic [3:0] OPND_HI   = 4'h3;

  function automatic logic is_operand(input logic [7:0] b);
    return b[7:4] == OPND_HI;
  endfunction

endpackage

// File: rtl/l2_rdy_timer.sv
// Loadable up-counter with clear and enable; flags the last cycle of the ready window.
module l2_rdy_timer #(
  parameter int unsigned RDY_TIMEOUT = 16,
  localparam int unsigned TW = (RDY_TIMEOUT > 1) ? $clog2(RDY_TIMEOUT) : 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr_i,
  input  logic          en_i,
  input  logic          load_i,
  input  logic [TW-1:0] load_val_i,
  output logic          expired_o
);

  logic [TW-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired_o = (cnt_q == TW'(RDY_TIMEOUT - 1));

endmodule

// File: rtl/l2_cmd_collector.sv
// Assembles "<op1><+|-><op2><TERM>" from a UART byte stream and launches the adder.
module l2_cmd_collector
  import l2_pkg::*;
#(
  parameter int unsigned RDY_TIMEOUT = 16,
  parameter logic [7:0]  TERM_CHAR   = ASC_CR,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             Gl_rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  input  logic             L2_adder_rdy,
  output logic [7:0]       Gl_r1,
  output logic [7:0]       Gl_r2,
  output logic             Gl_subtract,
  output logic             Gl_adder_start,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] drop_cnt
);

  l2_state_e        state_q;
  logic [7:0]       r1_q, r2_q;
  logic             sub_q, start_q, busy_q, err_q;
  logic [CNT_W-1:0] drop_cnt_q;
  logic             in_busy, term_hit, timer_expired;

  assign in_busy  = (state_q == S_START) || (state_q == S_WAIT);
  assign term_hit = (state_q == S_TERM) && rx_valid && (rx_data == TERM_CHAR);

  // Cleared on entry to S_START so the count covers the start cycle; expiry then
  // lands exactly RDY_TIMEOUT cycles after the start pulse.
  l2_rdy_timer #(
    .RDY_TIMEOUT(RDY_TIMEOUT)
  ) u_rdy_timer (
    .clk_i      (clk),
    .rst_i      (Gl_rst),
    .clr_i      (term_hit),
    .en_i       ((state_q == S_START) || ((state_q == S_WAIT) && !L2_adder_rdy && !timer_expired)),
    .load_i     (1'b0),
    .load_val_i ('0),
    .expired_o  (timer_expired)
  );

  always_ff @(posedge clk) begin
    if (Gl_rst) begin
      state_q    <= S_A;
      r1_q       <= '0;
      r2_q       <= '0;
      sub_q      <= 1'b0;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      start_q <= 1'b0;
      err_q   <= 1'b0;
      if (rx_valid && in_busy && (drop_cnt_q != '1)) begin
        drop_cnt_q <= drop_cnt_q + 1'b1;
      end
      unique case (state_q)
        S_A: begin
          if (rx_valid && is_operand(rx_data)) begin
            r1_q    <= rx_data;
            state_q <= S_OP;
          end
        end
        S_OP: begin
          if (rx_valid) begin
            if (rx_data == ASC_PLUS) begin
              sub_q   <= 1'b0;
              state_q <= S_B;
            end else if (rx_data == ASC_MINUS) begin
              sub_q   <= 1'b1;
              state_q <= S_B;
            end else begin
              err_q   <= 1'b1;
              state_q <= S_A;
            end
          end
        end
        S_B: begin
          if (rx_valid) begin
            if (is_operand(rx_data)) begin
              r2_q    <= rx_data;
              state_q <= S_TERM;
            end else begin
              err_q   <= 1'b1;
              state_q <= S_A;
            end
          end
        end
        S_TERM: begin
          if (term_hit) begin
            start_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= S_START;
          end else if (rx_valid) begin
            err_q   <= 1'b1;
            state_q <= S_A;
          end
        end
        S_START: begin
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (L2_adder_rdy) begin
            busy_q  <= 1'b0;
            state_q <= S_A;
          end else if (timer_expired) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_A;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_A;
        end
      endcase
    end
  end

  assign Gl_r1          = r1_q;
  assign Gl_r2          = r2_q;
  assign Gl_subtract    = sub_q;
  assign Gl_adder_start = start_q;
  assign busy           = busy_q;
  assign err            = err_q;
  assign drop_cnt       = drop_cnt_q;

endmodule

// File: tb/tb_l2_cmd_collector.sv
// Scoreboard bench for l2_cmd_collector: byte-buffer reference model feeds an event queue.
module tb_l2_cmd_collector;

  localparam int RDY_TIMEOUT = 16;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             Gl_rst, rx_valid, L2_adder_rdy;
  logic [7:0]       rx_data;
  logic [7:0]       Gl_r1, Gl_r2;
  logic             Gl_subtract, Gl_adder_start, busy, err;
  logic [CNT_W-1:0] drop_cnt;

  always #5 clk = ~clk;

  l2_cmd_collector #(
    .RDY_TIMEOUT(RDY_TIMEOUT),
    .TERM_CHAR  (8'h0D),
    .CNT_W      (CNT_W)
  ) dut (
    .clk           (clk),
    .Gl_rst        (Gl_rst),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .L2_adder_rdy  (L2_adder_rdy),
    .Gl_r1         (Gl_r1),
    .Gl_r2         (Gl_r2),
    .Gl_subtract   (Gl_subtract),
    .Gl_adder_start(Gl_adder_start),
    .busy          (busy),
    .err           (err),
    .drop_cnt      (drop_cnt)
  );

  typedef struct {
    bit         is_err;
    logic [7:0] r1;
    logic [7:0] r2;
    logic       sub;
  } exp_t;

  exp_t       expq[$];
  int         n_chk = 0;
  int         n_fail = 0;
  logic [7:0] cmd[$];
  bit         model_busy = 0;
  int         m_drop = 0;
  int         raw_drops = 0;
  logic [7:0] held_r1, held_r2;
  logic       held_sub;
  bit         hold_valid = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_opnd(input logic [7:0] b);
    return b >= 8'h30 && b <= 8'h3F;
  endfunction

  function automatic void push_err();
    exp_t e;
    e.is_err = 1;
    e.r1 = '0;
    e.r2 = '0;
    e.sub = 1'b0;
    expq.push_back(e);
  endfunction

  // Reference: a byte buffer holding the partial command; any rule violation empties it.
  function automatic void model_byte(input logic [7:0] b);
    exp_t e;
    if (model_busy) begin
      raw_drops++;
      if (m_drop < (1 << CNT_W) - 1) m_drop++;
      return;
    end
    case (cmd.size())
      0: if (is_opnd(b)) cmd.push_back(b);
      1: if (b == 8'h2B || b == 8'h2D) cmd.push_back(b);
         else begin push_err(); cmd.delete(); end
      2: if (is_opnd(b)) cmd.push_back(b);
         else begin push_err(); cmd.delete(); end
      default: begin
        if (b == 8'h0D) begin
          e.is_err = 0;
          e.r1 = cmd[0];
          e.r2 = cmd[2];
          e.sub = (cmd[1] == 8'h2D);
          expq.push_back(e);
          model_busy = 1;
        end else begin
          push_err();
        end
        cmd.delete();
      end
    endcase
  endfunction

  task automatic send_byte(input logic [7:0] b);
    model_byte(b);
    rx_data = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_cmd(input logic [7:0] a, input logic [7:0] op, input logic [7:0] b);
    send_byte(a);
    send_byte(op);
    send_byte(b);
    send_byte(8'h0D);
    check("start_latency", Gl_adder_start, 1);
    check("busy_on_start", busy, 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      L2_adder_rdy = 1'($urandom_range(0, 1));
      @(negedge clk);
      L2_adder_rdy = 1'b0;
    end
  endtask

  // Iteration i is sampled i edges after the start pulse appeared.
  task automatic finish_rdy(input int d, input int nbytes, input bit rdy_with_byte);
    logic [7:0] b;
    bit drv;
    for (int i = 1; i <= d; i++) begin
      drv = (i <= nbytes) || (i == d && rdy_with_byte);
      if (drv) begin
        b = 8'($urandom);
        model_byte(b);
        rx_data = b;
        rx_valid = 1'b1;
      end
      L2_adder_rdy = (i == d);
      @(negedge clk);
      rx_valid = 1'b0;
      L2_adder_rdy = 1'b0;
      if (i < d) check("busy_hold", busy, 1);
    end
    model_busy = 0;
    check("busy_after_rdy", busy, 0);
    check("drop_cnt", drop_cnt, m_drop);
  endtask

  task automatic finish_timeout(input int nbytes, input bit rdy_in_start);
    logic [7:0] b;
    int cnt;
    bit got;
    cnt = 0;
    got = 0;
    push_err();
    for (int i = 1; i <= 40 && !got; i++) begin
      if (i <= nbytes) begin
        b = 8'($urandom);
        model_byte(b);
        rx_data = b;
        rx_valid = 1'b1;
      end
      L2_adder_rdy = rdy_in_start && (i == 1);
      @(negedge clk);
      rx_valid = 1'b0;
      L2_adder_rdy = 1'b0;
      cnt = i;
      if (err) got = 1;
    end
    check("timeout_latency", cnt, RDY_TIMEOUT);
    model_busy = 0;
    check("busy_after_timeout", busy, 0);
    check("drop_cnt", drop_cnt, m_drop);
  endtask

  task automatic do_reset();
    Gl_rst = 1'b1;
    @(negedge clk);
    Gl_rst = 1'b0;
    cmd.delete();
    model_busy = 0;
    m_drop = 0;
    hold_valid = 0;
  endtask

  task automatic check_zero();
    check("rst_r1", Gl_r1, 0);
    check("rst_r2", Gl_r2, 0);
    check("rst_sub", Gl_subtract, 0);
    check("rst_start", Gl_adder_start, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_drop", drop_cnt, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!Gl_rst) begin
      if (Gl_adder_start || err) begin
        check("start_err_exclusive", Gl_adder_start && err, 0);
        if (expq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_event: start=%0b err=%0b with nothing expected at %0t",
                   Gl_adder_start, err, $time);
        end else begin
          e = expq.pop_front();
          check("event_is_err", err, e.is_err);
          if (!e.is_err) begin
            check("start_r1", Gl_r1, e.r1);
            check("start_r2", Gl_r2, e.r2);
            check("start_sub", Gl_subtract, e.sub);
            held_r1 = e.r1;
            held_r2 = e.r2;
            held_sub = e.sub;
            hold_valid = 1;
          end
        end
      end
      if (busy && hold_valid) begin
        check("hold_r1", Gl_r1, held_r1);
        check("hold_r2", Gl_r2, held_r2);
        check("hold_sub", Gl_subtract, held_sub);
      end
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] by[4];
    logic [7:0] bad;
    int p, d;
    Gl_rst = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    L2_adder_rdy = 1'b0;
    repeat (2) @(negedge clk);
    Gl_rst = 1'b0;
    check_zero();

    // Add path, rdy 5 cycles later
    send_cmd(8'h33, 8'h2B, 8'h34);
    check("add_r1", Gl_r1, 8'h33);
    check("add_r2", Gl_r2, 8'h34);
    check("add_sub", Gl_subtract, 0);
    finish_rdy(5, 0, 0);

    // Subtract path with dropped bytes while waiting
    send_cmd(8'h39, 8'h2D, 8'h32);
    check("sub_flag", Gl_subtract, 1);
    finish_rdy(9, 3, 0);

    // Malformed '*', then a normal command
    send_byte(8'h33);
    send_byte(8'h2A);
    check("err_on_star", err, 1);
    send_byte(8'h34);
    send_byte(8'h0D);
    check("no_start_malformed", Gl_adder_start, 0);
    send_cmd(8'h31, 8'h2B, 8'h31);
    finish_rdy(3, 0, 0);

    // Timeout; rdy during the start cycle must be ignored
    send_cmd(8'h37, 8'h2B, 8'h38);
    finish_timeout(4, 1);

    // Drop counter saturation; rdy coincides with a byte and with timer expiry
    while (raw_drops < 300) begin
      send_cmd(8'h30 | 8'($urandom_range(0, 15)), 8'h2B, 8'h30 | 8'($urandom_range(0, 15)));
      finish_rdy(16, 15, 1);
    end
    check("drop_saturated", drop_cnt, 255);

    // Reset mid-command (in S_B)
    send_byte(8'h33);
    send_byte(8'h2B);
    do_reset();
    check_zero();
    send_byte(8'h35);
    send_byte(8'h0D);
    check("no_start_after_rst", Gl_adder_start, 0);

    // Reset while waiting for rdy: no err may follow
    send_cmd(8'h36, 8'h2D, 8'h31);
    repeat (3) @(negedge clk);
    do_reset();
    check("busy_after_wait_rst", busy, 0);
    repeat (20) @(negedge clk);

    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 3) == 0) send_byte(8'h20);
      by[0] = 8'h30 | 8'($urandom_range(0, 15));
      by[1] = $urandom_range(0, 1) ? 8'h2D : 8'h2B;
      by[2] = 8'h30 | 8'($urandom_range(0, 15));
      by[3] = 8'h0D;
      if ($urandom_range(0, 3) == 0) begin
        p = $urandom_range(1, 3);
        do begin
          bad = 8'($urandom);
        end while ((p == 1) ? (bad == 8'h2B || bad == 8'h2D) :
                   (p == 2) ? is_opnd(bad) : (bad == 8'h0D));
        by[p] = bad;
      end
      for (int j = 0; j < 4 && !model_busy; j++) begin
        idle($urandom_range(0, 2));
        send_byte(by[j]);
      end
      if (model_busy) begin
        check("start_latency", Gl_adder_start, 1);
        if ($urandom_range(0, 5) == 0) begin
          finish_timeout($urandom_range(0, 16), 1'($urandom_range(0, 1)));
        end else begin
          d = $urandom_range(2, 16);
          finish_rdy(d, $urandom_range(0, d - 1), 1'($urandom_range(0, 1)));
        end
      end
    end

    repeat (20) @(negedge clk);
    check("queue_empty", expq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
